// File: rtl/enemy_attack_ctrl.sv
// Attacker-side punch controller: wind-up, strike, draw, cooldown.
// Owns the defender health register and raises hit/blocked pulses and the plot request.
module enemy_attack_ctrl #(
  parameter int WINDUP_CYCLES   = 4,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int DAMAGE          = 1,
  parameter int MAX_HEALTH      = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       punch,
  input  logic       can_be_hit,
  input  logic       plot_done,
  output logic [3:0] health,
  output logic       hit,
  output logic       blocked,
  output logic       plot,
  output logic       busy,
  output logic       dead
);

  localparam int CNT_MAX = (WINDUP_CYCLES > COOLDOWN_CYCLES) ? WINDUP_CYCLES : COOLDOWN_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] WINDUP_LOAD   = CNT_W'(WINDUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOLDOWN_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [3:0]       DMG           = 4'(DAMAGE);
  localparam logic [3:0]       HEALTH_INIT   = 4'(MAX_HEALTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WINDUP,
    S_STRIKE,
    S_DRAW,
    S_COOLDOWN,
    S_DEAD
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_nextCount;
  logic [3:0]       r_health;
  logic [3:0]       w_nextHealth;
  logic             r_hit;
  logic             w_nextHit;
  logic             r_blocked;
  logic             w_nextBlocked;
  logic             r_punchQ;
  logic             w_press;

  assign w_press = punch & ~r_punchQ;

  // punch_q resets high so a key held through reset does not count as a press
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_health  <= HEALTH_INIT;
      r_hit     <= 1'b0;
      r_blocked <= 1'b0;
      r_punchQ  <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_count   <= w_nextCount;
      r_health  <= w_nextHealth;
      r_hit     <= w_nextHit;
      r_blocked <= w_nextBlocked;
      r_punchQ  <= punch;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextCount   = r_count;
    w_nextHealth  = r_health;
    w_nextHit     = 1'b0;
    w_nextBlocked = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press) begin
          w_nextState = S_WINDUP;
          w_nextCount = WINDUP_LOAD;
        end
      end
      S_WINDUP: begin
        if (r_count == '0) w_nextState = S_STRIKE;
        else               w_nextCount = r_count - CNT_ONE;
      end
      // Health saturates at zero so a large hit never wraps back to full
      S_STRIKE: begin
        w_nextState = S_DRAW;
        if (can_be_hit) begin
          w_nextHealth = (r_health >= DMG) ? (r_health - DMG) : 4'd0;
          w_nextHit    = 1'b1;
        end else begin
          w_nextBlocked = 1'b1;
        end
      end
      S_DRAW: begin
        if (plot_done) begin
          if (r_health == 4'd0) begin
            w_nextState = S_DEAD;
          end else begin
            w_nextState = S_COOLDOWN;
            w_nextCount = COOLDOWN_LOAD;
          end
        end
      end
      S_COOLDOWN: begin
        if (r_count == '0) w_nextState = S_IDLE;
        else               w_nextCount = r_count - CNT_ONE;
      end
      S_DEAD: w_nextState = S_DEAD;
      default: w_nextState = S_IDLE;
    endcase
  end

  assign health  = r_health;
  assign hit     = r_hit;
  assign blocked = r_blocked;
  assign plot    = (r_state == S_DRAW);
  assign busy    = (r_state != S_IDLE);
  assign dead    = (r_state == S_DEAD);

endmodule

// File: tb/tb_enemy_attack_ctrl.sv
// Directed bench for enemy_attack_ctrl: a default instance plus a DAMAGE=4 instance
// share the same stimulus; each scenario task checks its own expectations.
module tb_enemy_attack_ctrl;

  logic       clock;
  logic       reset;
  logic       punch;
  logic       canBeHit;
  logic       plotDone;
  logic [3:0] healthA;
  logic       hitA, blockedA, plotA, busyA, deadA;
  logic [3:0] healthB;
  logic       hitB, blockedB, plotB, busyB, deadB;

  int checks;
  int failures;

  enemy_attack_ctrl dutA (
    .clock(clock), .reset(reset), .punch(punch), .can_be_hit(canBeHit),
    .plot_done(plotDone), .health(healthA), .hit(hitA), .blocked(blockedA),
    .plot(plotA), .busy(busyA), .dead(deadA)
  );

  enemy_attack_ctrl #(.DAMAGE(4)) dutB (
    .clock(clock), .reset(reset), .punch(punch), .can_be_hit(canBeHit),
    .plot_done(plotDone), .health(healthB), .hit(hitB), .blocked(blockedB),
    .plot(plotB), .busy(busyB), .dead(deadB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset    = 1'b1;
    punch    = 1'b0;
    canBeHit = 1'b1;
    plotDone = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (healthA !== 4'd15) begin failures++; $display("[TB] FAIL reset_health got %0d want 15", healthA); end
    checks++; if ({hitA, blockedA, plotA, busyA, deadA} !== 5'b0) begin failures++; $display("[TB] FAIL reset_flags got %b want 00000", {hitA, blockedA, plotA, busyA, deadA}); end
    checks++; if (healthB !== 4'd15) begin failures++; $display("[TB] FAIL reset_healthB got %0d want 15", healthB); end
  endtask

  task automatic test_hit();
    doReset();
    punch = 1'b1;
    tick(1);
    punch = 1'b0;
    checks++; if (busyA !== 1'b1) begin failures++; $display("[TB] FAIL hit_busy_windup got %b want 1", busyA); end
    tick(4);
    checks++; if (hitA !== 1'b0 || plotA !== 1'b0) begin failures++; $display("[TB] FAIL hit_strike_early got hit=%b plot=%b want 0 0", hitA, plotA); end
    tick(1);
    checks++; if (hitA !== 1'b1) begin failures++; $display("[TB] FAIL hit_pulse got %b want 1", hitA); end
    checks++; if (healthA !== 4'd14) begin failures++; $display("[TB] FAIL hit_health got %0d want 14", healthA); end
    checks++; if (plotA !== 1'b1) begin failures++; $display("[TB] FAIL hit_plot got %b want 1", plotA); end
    tick(1);
    checks++; if (hitA !== 1'b0 || plotA !== 1'b1) begin failures++; $display("[TB] FAIL hit_pulse_width got hit=%b plot=%b want 0 1", hitA, plotA); end
    plotDone = 1'b1;
    tick(1);
    plotDone = 1'b0;
    checks++; if (plotA !== 1'b0 || busyA !== 1'b1) begin failures++; $display("[TB] FAIL hit_cooldown_entry got plot=%b busy=%b want 0 1", plotA, busyA); end
    tick(7);
    checks++; if (busyA !== 1'b1) begin failures++; $display("[TB] FAIL hit_cooldown_len got busy=%b want 1", busyA); end
    tick(1);
    checks++; if (busyA !== 1'b0) begin failures++; $display("[TB] FAIL hit_idle got busy=%b want 0", busyA); end
  endtask

  task automatic test_blocked();
    doReset();
    canBeHit = 1'b0;
    punch = 1'b1;
    tick(1);
    punch = 1'b0;
    tick(5);
    checks++; if (blockedA !== 1'b1 || hitA !== 1'b0) begin failures++; $display("[TB] FAIL blk_pulse got blocked=%b hit=%b want 1 0", blockedA, hitA); end
    checks++; if (healthA !== 4'd15) begin failures++; $display("[TB] FAIL blk_health got %0d want 15", healthA); end
    tick(1);
    checks++; if (blockedA !== 1'b0) begin failures++; $display("[TB] FAIL blk_pulse_width got %b want 0", blockedA); end
  endtask

  task automatic test_saturate_dead();
    logic [3:0] expHealth [4];
    expHealth[0] = 4'd11; expHealth[1] = 4'd7; expHealth[2] = 4'd3; expHealth[3] = 4'd0;
    doReset();
    for (int k = 0; k < 4; k++) begin
      punch = 1'b1;
      tick(1);
      punch = 1'b0;
      tick(5);
      checks++; if (healthB !== expHealth[k] || hitB !== 1'b1) begin failures++; $display("[TB] FAIL dmg_attack%0d got health=%0d hit=%b want %0d 1", k, healthB, hitB, expHealth[k]); end
      plotDone = 1'b1;
      tick(1);
      plotDone = 1'b0;
      if (k < 3) tick(8);
    end
    checks++; if (deadB !== 1'b1 || busyB !== 1'b1 || plotB !== 1'b0) begin failures++; $display("[TB] FAIL dmg_dead got dead=%b busy=%b plot=%b want 1 1 0", deadB, busyB, plotB); end
    punch = 1'b1;
    tick(1);
    punch = 1'b0;
    tick(10);
    checks++; if (deadB !== 1'b1 || healthB !== 4'd0 || hitB !== 1'b0) begin failures++; $display("[TB] FAIL dmg_dead_sticky got dead=%b health=%0d hit=%b want 1 0 0", deadB, healthB, hitB); end
  endtask

  task automatic test_held_key();
    int hitCount;
    doReset();
    plotDone = 1'b1;
    punch = 1'b1;
    hitCount = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (hitA === 1'b1) hitCount++;
    end
    checks++; if (hitCount !== 1) begin failures++; $display("[TB] FAIL held_hits got %0d want 1", hitCount); end
    checks++; if (healthA !== 4'd14 || busyA !== 1'b0) begin failures++; $display("[TB] FAIL held_health got health=%0d busy=%b want 14 0", healthA, busyA); end
    punch = 1'b0;
    tick(1);
    punch = 1'b1;
    tick(1);
    punch = 1'b0;
    tick(6);
    checks++; if (busyA !== 1'b1 || plotA !== 1'b0 || healthA !== 4'd13) begin failures++; $display("[TB] FAIL held_cooldown got busy=%b plot=%b health=%0d want 1 0 13", busyA, plotA, healthA); end
    tick(2);
    punch = 1'b1;
    tick(1);
    punch = 1'b0;
    hitCount = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (hitA === 1'b1) hitCount++;
    end
    checks++; if (hitCount !== 0 || busyA !== 1'b0 || healthA !== 4'd13) begin failures++; $display("[TB] FAIL held_drop got hits=%0d busy=%b health=%0d want 0 0 13", hitCount, busyA, healthA); end
    plotDone = 1'b0;
  endtask

  task automatic test_slow_plot();
    int plotCount;
    doReset();
    punch = 1'b1;
    tick(1);
    punch = 1'b0;
    tick(5);
    plotCount = (plotA === 1'b1) ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      if (plotA === 1'b1) plotCount++;
    end
    checks++; if (plotCount !== 10) begin failures++; $display("[TB] FAIL slow_plot_cycles got %0d want 10", plotCount); end
    plotDone = 1'b1;
    tick(1);
    plotDone = 1'b0;
    checks++; if (plotA !== 1'b0 || busyA !== 1'b1) begin failures++; $display("[TB] FAIL slow_cooldown_entry got plot=%b busy=%b want 0 1", plotA, busyA); end
    tick(7);
    checks++; if (busyA !== 1'b1) begin failures++; $display("[TB] FAIL slow_cooldown_len got busy=%b want 1", busyA); end
    tick(1);
    checks++; if (busyA !== 1'b0) begin failures++; $display("[TB] FAIL slow_idle got busy=%b want 0", busyA); end
  endtask

  task automatic test_reset_mid_attack();
    int hitCount;
    doReset();
    punch = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if (healthA !== 4'd15 || {hitA, blockedA, plotA, busyA, deadA} !== 5'b0) begin failures++; $display("[TB] FAIL abort_state got health=%0d flags=%b want 15 00000", healthA, {hitA, blockedA, plotA, busyA, deadA}); end
    hitCount = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (hitA === 1'b1 || busyA === 1'b1) hitCount++;
    end
    checks++; if (hitCount !== 0 || healthA !== 4'd15) begin failures++; $display("[TB] FAIL abort_no_hit got activity=%0d health=%0d want 0 15", hitCount, healthA); end
    punch = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    punch    = 1'b0;
    canBeHit = 1'b1;
    plotDone = 1'b0;
    test_reset();
    test_hit();
    test_blocked();
    test_saturate_dead();
    test_held_key();
    test_slow_plot();
    test_reset_mid_attack();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
